// File: rtl/bpsk_symbol_slicer_pkg.sv
// Shared types and defaults for the BPSK symbol slicer.
// The lock FSM encoding, nominal 9600 Bd constants and a symmetric clamp helper.
package bpsk_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam logic [31:0]        SYM_INCR_9600 = 32'd412317;
  localparam logic signed [31:0] CORR_MAX_DEF  = 32'sd536870912;

  function automatic logic signed [31:0] clamp32(input logic signed [31:0] x,
                                                input logic signed [31:0] lim);
    if (x > lim) begin
      return lim;
    end else if (x < -lim) begin
      return -lim;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/bpsk_symbol_slicer_if.sv
// Sample-in / symbol-out bundle between the Costas loop side and the slicer.
// master drives samples and enable, slave is the slicer.
interface bpsk_symbol_slicer_if;
  logic        en;
  logic [13:0] us_demodin;
  logic        bit_out;
  logic        bit_valid;
  logic        locked;
  logic [9:0]  sym_phase;

  modport master (output en, us_demodin,
                  input  bit_out, bit_valid, locked, sym_phase);
  modport slave  (input  en, us_demodin,
                  output bit_out, bit_valid, locked, sym_phase);
endinterface

// File: rtl/bpsk_symbol_slicer_zc.sv
// Hysteresis slicer and zero-crossing timing detector.
// Produces the crossing strobe, the clamped phase correction and the lock score.
module zc_timing_detector
  import bpsk_pkg::*;
#(
  parameter logic signed [13:0] HYST     = 14'sd256,
  parameter int                 ZC_SHIFT = 2,
  parameter logic signed [31:0] CORR_MAX = CORR_MAX_DEF,
  parameter logic signed [31:0] LOCK_WIN = 32'sd268435456
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic signed [13:0] i_sample,
  input  logic [31:0]        i_acc,
  output logic               o_zc,
  output logic signed [31:0] o_corr,
  output logic [7:0]         o_score
);

  localparam logic [31:0] LOCK_WIN_U = LOCK_WIN;

  logic               r_sgn;
  logic [7:0]         r_score;
  logic               w_sgn_nxt;
  logic               w_zc;
  logic signed [31:0] w_err;
  logic [31:0]        w_err_abs;
  logic               w_good;

  always_comb begin
    w_sgn_nxt = r_sgn;
    if (i_sample > HYST) begin
      w_sgn_nxt = 1'b1;
    end else if (i_sample < -HYST) begin
      w_sgn_nxt = 1'b0;
    end
  end

  // The ideal crossing sits at acc == 0, so the signed accumulator is the error.
  assign w_zc      = i_en & (w_sgn_nxt ^ r_sgn);
  assign w_err     = signed'(i_acc);
  assign w_err_abs = w_err[31] ? (~i_acc + 32'd1) : i_acc;
  assign w_good    = (w_err_abs < LOCK_WIN_U);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn   <= 1'b0;
      r_score <= 8'd0;
    end else if (i_en) begin
      r_sgn <= w_sgn_nxt;
      if (w_zc) begin
        if (w_good) begin
          r_score <= (r_score == 8'd255) ? r_score : r_score + 8'd1;
        end else begin
          r_score <= (r_score < 8'd4) ? 8'd0 : r_score - 8'd4;
        end
      end
    end
  end

  assign o_zc    = w_zc;
  assign o_corr  = clamp32(w_err >>> ZC_SHIFT, CORR_MAX);
  assign o_score = r_score;

endmodule

// File: rtl/bpsk_symbol_slicer.sv
// BPSK symbol slicer: phase-accumulator symbol timing, integrate-and-dump, lock FSM.
// state  | meaning
// SEARCH | timing not trusted, waiting for enough good crossings
// LOCKED | crossings land near acc == 0, bits are considered valid
module bpsk_symbol_slicer
  import bpsk_pkg::*;
#(
  parameter logic [31:0]        SYM_INCR    = SYM_INCR_9600,
  parameter logic signed [13:0] HYST        = 14'sd256,
  parameter int                 ZC_SHIFT    = 2,
  parameter logic signed [31:0] CORR_MAX    = CORR_MAX_DEF,
  parameter logic signed [31:0] LOCK_WIN    = 32'sd268435456,
  parameter logic [7:0]         LOCK_THRESH = 8'd16
) (
  input  logic          clk,
  input  logic          rst,
  bpsk_symbol_slicer_if.slave bus
);

  localparam logic signed [32:0] INTEG_LIM33 = 33'sd2147483647;
  localparam logic signed [31:0] INTEG_MAX   = 32'sd2147483647;
  localparam logic [7:0]         UNLOCK_LVL  = LOCK_THRESH >> 1;

  lock_state_e        r_state;
  lock_state_e        w_state_nxt;
  logic [31:0]        r_acc;
  logic signed [31:0] r_integ;
  logic               r_bit_out;
  logic               r_bit_valid;

  logic signed [13:0] w_sample;
  logic               w_zc;
  logic signed [31:0] w_corr;
  logic [7:0]         w_score;
  logic [31:0]        w_acc_nxt;
  logic               w_wrap;
  logic signed [32:0] w_sum;
  logic signed [31:0] w_integ_sat;

  assign w_sample = {~bus.us_demodin[13], bus.us_demodin[12:0]};

  zc_timing_detector #(
    .HYST     (HYST),
    .ZC_SHIFT (ZC_SHIFT),
    .CORR_MAX (CORR_MAX),
    .LOCK_WIN (LOCK_WIN)
  ) u_zc (
    .clk      (clk),
    .rst      (rst),
    .i_en     (bus.en),
    .i_sample (w_sample),
    .i_acc    (r_acc),
    .o_zc     (w_zc),
    .o_corr   (w_corr),
    .o_score  (w_score)
  );

  assign w_acc_nxt = r_acc + SYM_INCR - (w_zc ? $unsigned(w_corr) : 32'd0);
  assign w_wrap    = r_acc[31] & ~w_acc_nxt[31];

  // 33-bit sum cannot overflow, so its sign bit is the slicer decision.
  always_comb begin
    w_sum       = {r_integ[31], r_integ} + {{19{w_sample[13]}}, w_sample};
    w_integ_sat = w_sum[31:0];
    if (w_sum > INTEG_LIM33) begin
      w_integ_sat = INTEG_MAX;
    end else if (w_sum < -INTEG_LIM33) begin
      w_integ_sat = -INTEG_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= 32'd0;
      r_integ     <= 32'sd0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
    end else if (bus.en) begin
      r_acc <= w_acc_nxt;
      if (w_wrap) begin
        r_bit_out   <= ~w_sum[32];
        r_bit_valid <= 1'b1;
        r_integ     <= 32'sd0;
      end else begin
        r_integ     <= w_integ_sat;
        r_bit_valid <= 1'b0;
      end
    end else begin
      r_bit_valid <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEARCH:  if (w_score >= LOCK_THRESH) w_state_nxt = LOCKED;
      LOCKED:  if (w_score < UNLOCK_LVL)   w_state_nxt = SEARCH;
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEARCH;
    end else if (bus.en) begin
      r_state <= w_state_nxt;
    end
  end

  assign bus.bit_out   = r_bit_out;
  assign bus.bit_valid = r_bit_valid;
  assign bus.locked    = (r_state == LOCKED);
  assign bus.sym_phase = r_acc[31:22];

endmodule

// File: tb/tb_bpsk_symbol_slicer.sv
// Scoreboard bench for bpsk_symbol_slicer at 16 samples per symbol.
// A sample-level arithmetic model predicts bits, phase and lock; a monitor checks strobed bits.
module tb_bpsk_symbol_slicer;

  localparam longint TWO32 = 64'h1_0000_0000;
  localparam longint HALF  = 64'h8000_0000;
  localparam longint INC   = 64'h1000_0000;
  localparam longint CMAX  = 64'h2000_0000;
  localparam longint LWIN  = 64'h1000_0000;
  localparam longint IMAX  = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpsk_symbol_slicer_if bus();

  bpsk_symbol_slicer #(.SYM_INCR(32'h1000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  longint m_acc, m_integ;
  int     m_score;
  bit     m_sgn, m_locked;
  bit     exp_q[$];

  int step_idx, first_valid, vcnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_integ = 0; m_score = 0; m_sgn = 0; m_locked = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [13:0] d);
    longint s, err, aerr, corr, nxt, sum;
    bit ns, zc;
    s  = longint'(d) - 8192;
    ns = m_sgn;
    if (s > 256) ns = 1;
    else if (s < -256) ns = 0;
    zc   = (ns != m_sgn);
    err  = (m_acc >= HALF) ? m_acc - TWO32 : m_acc;
    aerr = (err < 0) ? -err : err;
    corr = 0;
    if (zc) begin
      corr = (err >= 0) ? err / 4 : -((-err + 3) / 4);
      if (corr > CMAX) corr = CMAX;
      if (corr < -CMAX) corr = -CMAX;
    end
    nxt = m_acc + INC - corr;
    while (nxt < 0) nxt += TWO32;
    nxt = nxt % TWO32;
    sum = m_integ + s;
    if (m_acc >= HALF && nxt < HALF) begin
      exp_q.push_back(sum >= 0);
      m_integ = 0;
    end else begin
      m_integ = (sum > IMAX) ? IMAX : (sum < -IMAX) ? -IMAX : sum;
    end
    if (!m_locked && m_score >= 16) m_locked = 1;
    else if (m_locked && m_score < 8) m_locked = 0;
    if (zc) m_score = (aerr < LWIN) ? ((m_score + 1 > 255) ? 255 : m_score + 1)
                                    : ((m_score - 4 < 0) ? 0 : m_score - 4);
    m_acc = nxt;
    m_sgn = ns;
  endtask

  task automatic step(input bit e, input logic [13:0] d);
    @(negedge clk);
    bus.en = e;
    bus.us_demodin = d;
    if (e) model_step(d);
    @(posedge clk);
    #1;
    chk("sym_phase", longint'(bus.sym_phase), longint'(m_acc[31:22]));
    chk("locked", longint'(bus.locked), longint'(m_locked));
    if (!e) chk("valid_en_low", longint'(bus.bit_valid), 0);
    step_idx++;
    if (bus.bit_valid) begin
      vcnt++;
      if (first_valid < 0) first_valid = step_idx;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.en = 1'($urandom);
      bus.us_demodin = 14'($urandom);
      @(posedge clk);
      #1;
      chk("rst_bit_out", longint'(bus.bit_out), 0);
      chk("rst_bit_valid", longint'(bus.bit_valid), 0);
      chk("rst_locked", longint'(bus.locked), 0);
      chk("rst_sym_phase", longint'(bus.sym_phase), 0);
    end
    model_reset();
    rst = 1'b0;
    step_idx = 0; first_valid = -1; vcnt = 0;
  endtask

  function automatic logic [13:0] sq(input int k);
    return ((k >= 0) && (((k / 16) % 2) == 0)) ? 14'h2FA0 : 14'h1060;
  endfunction

  // Monitor: every strobed bit must match the oldest predicted symbol.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus.bit_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=1 required=0 at %0t", $time);
        end else begin
          chk("bit_out", longint'(bus.bit_out), longint'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int k, hp, amp, len, mode, val;
    bus.en = 1'b0;
    bus.us_demodin = 14'h0;

    do_reset(5);
    step(1'b1, 14'h3FFF);
    chk("post_release_valid", longint'(bus.bit_valid), 0);
    for (int i = 1; i < 80; i++) step(1'b1, 14'h3FFF);
    chk("pos_first_valid_step", first_valid, 16);
    chk("pos_valid_count", vcnt, 5);
    chk("pos_locked", longint'(bus.locked), 0);

    do_reset(2);
    for (int i = 0; i < 80; i++) step(1'b1, 14'h0000);
    chk("neg_first_valid_step", first_valid, 16);
    chk("neg_valid_count", vcnt, 5);

    do_reset(2);
    k = 0;
    while (k < 400) begin
      if (k == 300 && step_idx < 310) begin
        for (int i = 0; i < 10; i++) step(1'b0, 14'($urandom));
      end
      step(1'b1, sq(k));
      k++;
    end
    chk("aligned_locked", longint'(bus.locked), 1);

    do_reset(2);
    for (int i = 0; i < 600; i++) step(1'b1, sq(i - 4));
    chk("offset_locked", longint'(bus.locked), 1);

    for (int i = 0; i < 64; i++) step(1'b1, 14'(8192 + $urandom_range(0, 400) - 200));
    chk("noise_keeps_lock", longint'(bus.locked), 1);

    for (int i = 0; i < 7; i++) step(1'b1, 14'h3FFF);
    do_reset(3);
    for (int i = 0; i < 40; i++) step(1'b1, 14'h3FFF);
    chk("midrst_first_valid_step", first_valid, 16);

    do_reset(2);
    k = 0;
    while (k < 1500) begin
      mode = int'($urandom_range(0, 2));
      len  = int'($urandom_range(64, 200));
      hp   = int'($urandom_range(12, 20));
      amp  = int'($urandom_range(300, 8000));
      for (int i = 0; i < len; i++) begin
        case (mode)
          0:       val = (((i / hp) % 2) == 0) ? amp : -amp;
          1:       val = int'($urandom_range(0, 400)) - 200;
          default: val = int'($urandom_range(0, 16383)) - 8192;
        endcase
        step(($urandom_range(0, 9) != 0), 14'(8192 + val));
      end
      k += len;
    end

    step(1'b0, 14'h0);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
